// File: rtl/tracking_accum_pkg.sv
// rtl/tracking_accum_pkg.sv - shared types, record packing and saturation limits for the tracking accumulator
package tracking_accum_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Helpers work at a fixed maximum width; callers cast down to their own ACC_WIDTH.
    localparam int MAX_ACC_WIDTH = 32;

    typedef logic [MAX_ACC_WIDTH-1:0]   acc_max_t;
    typedef logic [2*MAX_ACC_WIDTH-1:0] rec_max_t;

    // Most positive w-bit two's complement value, as a bit pattern.
    function automatic acc_max_t sat_hi(input int w);
        return (acc_max_t'(1) << (w - 1)) - acc_max_t'(1);
    endfunction

    // Most negative w-bit two's complement value, as a bit pattern.
    function automatic acc_max_t sat_lo(input int w);
        return acc_max_t'(1) << (w - 1);
    endfunction

    function automatic rec_max_t rec_mask(input int w);
        return (rec_max_t'(1) << w) - rec_max_t'(1);
    endfunction

    // Record layout is {i_acc, q_acc}, each w bits wide.
    function automatic rec_max_t rec_pack(input acc_max_t i_acc, input acc_max_t q_acc, input int w);
        return ((rec_max_t'(i_acc) & rec_mask(w)) << w) | (rec_max_t'(q_acc) & rec_mask(w));
    endfunction

    function automatic acc_max_t rec_unpack_i(input rec_max_t r, input int w);
        return acc_max_t'((r >> w) & rec_mask(w));
    endfunction

    function automatic acc_max_t rec_unpack_q(input rec_max_t r, input int w);
        return acc_max_t'(r & rec_mask(w));
    endfunction

endpackage

// File: rtl/tracking_accum_sat_add.sv
// rtl/tracking_accum_sat_add.sv - signed accumulator plus sample adder with clamping
module sat_add
    import tracking_accum_pkg::*;
#(
    parameter int ACC_WIDTH = 20,
    parameter int IN_WIDTH  = 8
) (
    input  logic signed [ACC_WIDTH-1:0] acc_i,
    input  logic signed [IN_WIDTH-1:0]  x_i,
    output logic signed [ACC_WIDTH-1:0] sum_o
);

    typedef logic signed [ACC_WIDTH-1:0] acc_t;

    localparam acc_t SAT_HI = acc_t'(sat_hi(ACC_WIDTH));
    localparam acc_t SAT_LO = acc_t'(sat_lo(ACC_WIDTH));

    logic signed [ACC_WIDTH:0] full;

    // One guard bit: overflow shows up as the top two bits disagreeing.
    always_comb begin
        full = (ACC_WIDTH + 1)'(acc_i) + (ACC_WIDTH + 1)'(x_i);
        if (full[ACC_WIDTH] != full[ACC_WIDTH-1]) begin
            sum_o = full[ACC_WIDTH] ? SAT_LO : SAT_HI;
        end else begin
            sum_o = full[ACC_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/tracking_accum_rmw.sv
// rtl/tracking_accum_rmw.sv - per-channel I/Q accumulator with pipelined RAM read-modify-write
module tracking_accum_rmw
    import tracking_accum_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int IN_WIDTH   = 8,
    parameter int ACC_WIDTH  = 20
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          req_valid,
    input  logic [ADDR_WIDTH-1:0]         req_ch,
    input  logic signed [IN_WIDTH-1:0]    req_i,
    input  logic signed [IN_WIDTH-1:0]    req_q,
    input  logic                          req_dump,
    output logic                          busy,
    output logic [ADDR_WIDTH-1:0]         address_a,
    input  logic [2*ACC_WIDTH-1:0]        q_a,
    output logic [ADDR_WIDTH-1:0]         address_b,
    output logic [2*ACC_WIDTH-1:0]        data_b,
    output logic                          wren_b,
    output logic                          dump_valid,
    output logic [ADDR_WIDTH-1:0]         dump_ch,
    output logic signed [ACC_WIDTH-1:0]   dump_i,
    output logic signed [ACC_WIDTH-1:0]   dump_q
);

    typedef logic signed [ACC_WIDTH-1:0] acc_t;
    typedef logic [2*ACC_WIDTH-1:0]      rec_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   init_addr_q, init_addr_d;

    logic                    s1_v_q, s1_dump_q, s2_v_q, s2_dump_q;
    logic [ADDR_WIDTH-1:0]   s1_ch_q, s2_ch_q;
    logic signed [IN_WIDTH-1:0] s1_i_q, s1_qs_q, s2_i_q, s2_qs_q;

    logic                    w_v_q, w_dump_q;
    acc_t                    w_i_q, w_qs_q;
    logic                    wd_v_q;
    logic [ADDR_WIDTH-1:0]   wd_ch_q;
    rec_t                    wd_data_q;

    logic                    wren_b_q, dump_valid_q;
    logic [ADDR_WIDTH-1:0]   address_b_q, dump_ch_q;
    rec_t                    data_b_q;
    acc_t                    dump_i_q, dump_qs_q;

    acc_t                    old_i, old_q, new_i, new_q;
    rec_t                    new_rec;
    logic                    accept;

    assign busy       = (state_q == ST_INIT);
    assign address_a  = req_ch;
    assign accept     = req_valid && !busy;
    assign address_b  = address_b_q;
    assign data_b     = data_b_q;
    assign wren_b     = wren_b_q;
    assign dump_valid = dump_valid_q;
    assign dump_ch    = dump_ch_q;
    assign dump_i     = dump_i_q;
    assign dump_q     = dump_qs_q;

    // FSM state and init sweep counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
        end
    end

    // Sweep every channel to zero once, then run
    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        if (state_q == ST_INIT) begin
            init_addr_d = init_addr_q + 1'b1;
            if (init_addr_q == LAST_ADDR) begin
                state_d     = ST_RUN;
                init_addr_d = '0;
            end
        end
    end

    // S0 -> S1 -> S2 request pipeline while the RAM read is in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_v_q    <= 1'b0;
            s1_dump_q <= 1'b0;
            s1_ch_q   <= '0;
            s1_i_q    <= '0;
            s1_qs_q   <= '0;
            s2_v_q    <= 1'b0;
            s2_dump_q <= 1'b0;
            s2_ch_q   <= '0;
            s2_i_q    <= '0;
            s2_qs_q   <= '0;
        end else begin
            s1_v_q    <= accept;
            s1_dump_q <= req_dump;
            s1_ch_q   <= req_ch;
            s1_i_q    <= req_i;
            s1_qs_q   <= req_q;
            s2_v_q    <= s1_v_q;
            s2_dump_q <= s1_dump_q;
            s2_ch_q   <= s1_ch_q;
            s2_i_q    <= s1_i_q;
            s2_qs_q   <= s1_qs_q;
        end
    end

    // Old record: the two most recent writes may not be visible in q_a yet, newest wins
    always_comb begin
        old_i = acc_t'(rec_unpack_i(rec_max_t'(q_a), ACC_WIDTH));
        old_q = acc_t'(rec_unpack_q(rec_max_t'(q_a), ACC_WIDTH));
        if (w_v_q && address_b_q == s2_ch_q) begin
            old_i = w_dump_q ? '0 : w_i_q;
            old_q = w_dump_q ? '0 : w_qs_q;
        end else if (wd_v_q && wd_ch_q == s2_ch_q) begin
            old_i = acc_t'(rec_unpack_i(rec_max_t'(wd_data_q), ACC_WIDTH));
            old_q = acc_t'(rec_unpack_q(rec_max_t'(wd_data_q), ACC_WIDTH));
        end
    end

    sat_add #(.ACC_WIDTH(ACC_WIDTH), .IN_WIDTH(IN_WIDTH)) u_add_i (
        .acc_i (old_i),
        .x_i   (s2_i_q),
        .sum_o (new_i)
    );

    sat_add #(.ACC_WIDTH(ACC_WIDTH), .IN_WIDTH(IN_WIDTH)) u_add_q (
        .acc_i (old_q),
        .x_i   (s2_qs_q),
        .sum_o (new_q)
    );

    assign new_rec = rec_t'(rec_pack(acc_max_t'(new_i), acc_max_t'(new_q), ACC_WIDTH));

    // W stage: RAM write port, dump strobe, and the forwarding history
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wren_b_q     <= 1'b0;
            address_b_q  <= '0;
            data_b_q     <= '0;
            w_v_q        <= 1'b0;
            w_dump_q     <= 1'b0;
            w_i_q        <= '0;
            w_qs_q       <= '0;
            wd_v_q       <= 1'b0;
            wd_ch_q      <= '0;
            wd_data_q    <= '0;
            dump_valid_q <= 1'b0;
            dump_ch_q    <= '0;
            dump_i_q     <= '0;
            dump_qs_q    <= '0;
        end else begin
            if (state_q == ST_INIT) begin
                wren_b_q    <= 1'b1;
                address_b_q <= init_addr_q;
                data_b_q    <= '0;
            end else begin
                wren_b_q    <= s2_v_q;
                address_b_q <= s2_ch_q;
                data_b_q    <= s2_dump_q ? '0 : new_rec;
            end
            w_v_q        <= s2_v_q && !busy;
            w_dump_q     <= s2_dump_q;
            w_i_q        <= new_i;
            w_qs_q       <= new_q;
            wd_v_q       <= wren_b_q;
            wd_ch_q      <= address_b_q;
            wd_data_q    <= data_b_q;
            dump_valid_q <= s2_v_q && s2_dump_q && !busy;
            if (s2_v_q && s2_dump_q && !busy) begin
                dump_ch_q <= s2_ch_q;
                dump_i_q  <= new_i;
                dump_qs_q <= new_q;
            end
        end
    end

endmodule

// File: tb/tb_tracking_accum_rmw.sv
// tb/tb_tracking_accum_rmw.sv - directed self-checking bench for tracking_accum_rmw
module tb_tracking_accum_rmw;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int IW    = 8;
    localparam int ACCW  = 8;
    localparam int DW    = 2 * ACCW;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic                   req_valid, req_dump;
    logic [AW-1:0]          req_ch;
    logic signed [IW-1:0]   req_i, req_q;
    logic                   busy;
    logic [AW-1:0]          address_a, address_b, dump_ch;
    logic [DW-1:0]          q_a, data_b;
    logic                   wren_b, dump_valid;
    logic signed [ACCW-1:0] dump_i, dump_q;

    int total = 0;
    int bad   = 0;

    tracking_accum_rmw #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .IN_WIDTH(IW), .ACC_WIDTH(ACCW)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ch     (req_ch),
        .req_i      (req_i),
        .req_q      (req_q),
        .req_dump   (req_dump),
        .busy       (busy),
        .address_a  (address_a),
        .q_a        (q_a),
        .address_b  (address_b),
        .data_b     (data_b),
        .wren_b     (wren_b),
        .dump_valid (dump_valid),
        .dump_ch    (dump_ch),
        .dump_i     (dump_i),
        .dump_q     (dump_q)
    );

    always #5 clock = ~clock;

    // Channel-state RAM: registered address and registered output, old data on a same-edge collision
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ra_q;
    logic [DW-1:0] qa_q;
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(16'hA5C3 ^ i);
        end else if (wren_b) begin
            mem[address_b] <= data_b;
        end
        ra_q <= address_a;
        qa_q <= mem[ra_q];
    end
    assign q_a = qa_q;

    typedef struct {
        logic                   v;
        logic [AW-1:0]          ch;
        logic signed [IW-1:0]   i;
        logic signed [IW-1:0]   q;
        logic                   d;
        logic [DW-1:0]          edata;
        logic                   edv;
        logic signed [ACCW-1:0] edi;
        logic signed [ACCW-1:0] edq;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input int ch, input int i, input int q, input logic d,
                       input logic [DW-1:0] edata, input logic edv, input int edi, input int edq);
        vec_t t;
        t.v = v; t.ch = AW'(ch); t.i = IW'(i); t.q = IW'(q); t.d = d;
        t.edata = edata; t.edv = edv; t.edi = ACCW'(edi); t.edq = ACCW'(edq);
        tbl.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] ch, input logic signed [IW-1:0] i,
                         input logic signed [IW-1:0] q, input logic d);
        req_valid = v; req_ch = ch; req_i = i; req_q = q; req_dump = d;
    endtask

    initial begin
        drive(1'b0, '0, '0, '0, 1'b0);
        #3;
        chk("rst_busy", 32'(busy), 1);
        chk("rst_wren", 32'(wren_b), 0);
        chk("rst_dump_valid", 32'(dump_valid), 0);
        chk("rst_address_b", 32'(address_b), 0);
        chk("rst_data_b", 32'(data_b), 0);
        chk("rst_dump_i", 32'(dump_i), 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Init sweep with requests held on; they must be dropped
        drive(1'b1, 4'd7, 8'sd9, 8'sd9, 1'b1);
        for (int k = 0; k < DEPTH; k++) begin
            chk("init_busy", 32'(busy), 1);
            tick();
            chk("init_wren", 32'(wren_b), 1);
            chk("init_addr", 32'(address_b), 32'(k));
            chk("init_data", 32'(data_b), 0);
            chk("init_no_dump", 32'(dump_valid), 0);
        end
        chk("init_done_busy", 32'(busy), 0);
        drive(1'b0, '0, '0, '0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_init_no_wren", 32'(wren_b), 0);
            chk("post_init_no_dump", 32'(dump_valid), 0);
        end

        // v ch i q dump | data_b dump_valid dump_i dump_q
        add(1, 3, 5, -2, 0, 16'h05FE, 0, 0, 0);
        add(1, 3, 5, -2, 0, 16'h0AFC, 0, 0, 0);
        add(1, 3, 5, -2, 0, 16'h0FFA, 0, 0, 0);
        add(1, 3, 5, -2, 1, 16'h0000, 1, 20, -8);
        add(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0);
        add(1, 1, 1, 0, 0, 16'h0100, 0, 0, 0);
        add(1, 2, 1, 0, 0, 16'h0100, 0, 0, 0);
        add(1, 1, 1, 0, 0, 16'h0200, 0, 0, 0);
        add(1, 2, 1, 0, 0, 16'h0200, 0, 0, 0);
        add(1, 1, 1, 0, 0, 16'h0300, 0, 0, 0);
        add(1, 2, 1, 0, 0, 16'h0300, 0, 0, 0);
        add(1, 1, 0, 0, 1, 16'h0000, 1, 3, 0);
        add(1, 2, 0, 0, 1, 16'h0000, 1, 3, 0);
        add(1, 5, 2, 1, 0, 16'h0201, 0, 0, 0);
        add(1, 5, 1, 1, 1, 16'h0000, 1, 3, 2);
        add(1, 5, 7, 0, 0, 16'h0700, 0, 0, 0);
        add(1, 5, 0, 0, 1, 16'h0000, 1, 7, 0);
        add(1, 6, 1, 1, 0, 16'h0101, 0, 0, 0);
        add(1, 5, 4, -4, 0, 16'h04FC, 0, 0, 0);
        add(1, 5, 0, 0, 1, 16'h0000, 1, 4, -4);
        add(1, 0, 127, -128, 0, 16'h7F80, 0, 0, 0);
        add(1, 0, 127, -128, 0, 16'h7F80, 0, 0, 0);
        add(1, 0, 127, -128, 0, 16'h7F80, 0, 0, 0);
        add(1, 0, -128, 127, 0, 16'hFFFF, 0, 0, 0);
        add(1, 0, -128, 127, 0, 16'h807E, 0, 0, 0);
        add(1, 0, -128, 127, 0, 16'h807F, 0, 0, 0);
        add(1, 0, 0, 0, 1, 16'h0000, 1, -128, 127);
        add(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0);

        for (int k = 0; k < tbl.size() + 2; k++) begin
            if (k < tbl.size()) drive(tbl[k].v, tbl[k].ch, tbl[k].i, tbl[k].q, tbl[k].d);
            else drive(1'b0, '0, '0, '0, 1'b0);
            tick();
            if (k >= 2) begin
                vec_t e;
                e = tbl[k-2];
                chk($sformatf("vec%0d_wren", k - 2), 32'(wren_b), 32'(e.v));
                chk($sformatf("vec%0d_dump_valid", k - 2), 32'(dump_valid), 32'(e.v && e.edv));
                if (e.v) begin
                    chk($sformatf("vec%0d_address_b", k - 2), 32'(address_b), 32'(e.ch));
                    chk($sformatf("vec%0d_data_b", k - 2), 32'(data_b), 32'(e.edata));
                end
                if (e.v && e.edv) begin
                    chk($sformatf("vec%0d_dump_ch", k - 2), 32'(dump_ch), 32'(e.ch));
                    chk($sformatf("vec%0d_dump_i", k - 2), 32'(dump_i), 32'(e.edi));
                    chk($sformatf("vec%0d_dump_q", k - 2), 32'(dump_q), 32'(e.edq));
                end
            end
        end

        // Reset with three dump requests in flight
        drive(1'b1, 4'd9, 8'sd3, 8'sd3, 1'b1);
        tick();
        drive(1'b1, 4'd9, 8'sd4, 8'sd4, 1'b1);
        tick();
        drive(1'b1, 4'd10, 8'sd5, 8'sd5, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        drive(1'b0, '0, '0, '0, 1'b0);
        chk("midrst_wren", 32'(wren_b), 0);
        chk("midrst_dump_valid", 32'(dump_valid), 0);
        chk("midrst_busy", 32'(busy), 1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            tick();
            chk("reinit_wren", 32'(wren_b), 1);
            chk("reinit_addr", 32'(address_b), 32'(k));
            chk("reinit_data", 32'(data_b), 0);
            chk("reinit_no_dump", 32'(dump_valid), 0);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("reinit_quiet_wren", 32'(wren_b), 0);
            chk("reinit_quiet_dump", 32'(dump_valid), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
